// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: in-order hazard control (stall, flush, operand forwarding select, writeback port).
// Define PIPE_HAZARD_CTRL_FWD_EN for forwarding; otherwise any RAW match stalls until the producer retires.
module pipe_hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int REG_AW = 5,
    parameter int FLUSH_CYCLES = 2,
    localparam int SELW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_regwrite,
    input  logic              dec_late,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic              issue_legal,
    output logic [SELW-1:0]   fwd_sel1,
    output logic [SELW-1:0]   fwd_sel2,
    output logic              ex_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd
);
    logic [DEPTH-1:0]  st_valid;
    logic [DEPTH-1:0]  st_regwrite;
    logic [DEPTH-1:0]  st_late;
    logic [REG_AW-1:0] st_rd [DEPTH];
    logic [2:0]        fcnt;
    logic [DEPTH-1:0]  m1;
    logic [DEPTH-1:0]  m2;
    logic              branch_hit;
    logic              hazard;

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m1[k] = dec_use_rs1 & (dec_rs1 != '0) & st_valid[k] & st_regwrite[k] & (st_rd[k] == dec_rs1);
            m2[k] = dec_use_rs2 & (dec_rs2 != '0) & st_valid[k] & st_regwrite[k] & (st_rd[k] == dec_rs2);
        end
    end

    assign branch_hit  = ex_branch_taken & st_valid[0];
    assign flush       = branch_hit | (fcnt != '0);
    assign stall       = dec_valid & ~flush & hazard;
    assign issue_legal = dec_valid & ~stall & ~flush;
    assign ex_valid    = st_valid[0];
    assign wb_we       = st_valid[DEPTH-1] & st_regwrite[DEPTH-1] & (st_rd[DEPTH-1] != '0);
    assign wb_rd       = st_rd[DEPTH-1];

    // The pipe never freezes: a stalled or flushed slot enters stage 0 as a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_valid    <= '0;
            st_regwrite <= '0;
            st_late     <= '0;
            fcnt        <= '0;
            for (int k = 0; k < DEPTH; k++) st_rd[k] <= '0;
        end else begin
            st_valid    <= {st_valid[DEPTH-2:0], issue_legal};
            st_regwrite <= {st_regwrite[DEPTH-2:0], dec_regwrite};
            st_late     <= {st_late[DEPTH-2:0], dec_late};
            st_rd[0]    <= dec_rd;
            for (int k = 1; k < DEPTH; k++) st_rd[k] <= st_rd[k-1];
            fcnt        <= branch_hit ? 3'(FLUSH_CYCLES - 1) : ((fcnt != '0) ? fcnt - 1'b1 : fcnt);
        end
    end

`ifdef PIPE_HAZARD_CTRL_FWD_EN
    logic [SELW-1:0] sel1;
    logic [SELW-1:0] sel2;
    logic            late_hit;

    // Match at st[k] means the producer is at stage k+1 once the consumer reaches EX.
    always_comb begin
        sel1     = '0;
        sel2     = '0;
        late_hit = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m1[k]) sel1 = (k + 1 < DEPTH) ? SELW'(k + 1) : '0;
            if (m2[k]) sel2 = (k + 1 < DEPTH) ? SELW'(k + 1) : '0;
            if ((m1[k] | m2[k]) & st_late[k] & (k + 1 < DEPTH - 1)) late_hit = 1'b1;
        end
    end

    assign hazard = late_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_sel1 <= '0;
            fwd_sel2 <= '0;
        end else begin
            fwd_sel1 <= issue_legal ? sel1 : '0;
            fwd_sel2 <= issue_legal ? sel2 : '0;
        end
    end
`else
    logic unused_late;

    assign hazard      = |(m1 | m2);
    assign fwd_sel1    = '0;
    assign fwd_sel2    = '0;
    assign unused_late = ^st_late;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a per-stage expectation queue for EX and writeback.
module tb_pipe_hazard_ctrl;
    localparam int DEPTH = 3;
    localparam int REG_AW = 5;
    localparam int FLUSH_CYCLES = 2;
    localparam int SELW = 2;
`ifdef PIPE_HAZARD_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dec_valid;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic              dec_use_rs1, dec_use_rs2, dec_regwrite, dec_late;
    logic              ex_branch_taken;
    logic              stall, flush, issue_legal, ex_valid, wb_we;
    logic [SELW-1:0]   fwd_sel1, fwd_sel2;
    logic [REG_AW-1:0] wb_rd;

    pipe_hazard_ctrl #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_late(dec_late),
        .ex_branch_taken(ex_branch_taken), .stall(stall), .flush(flush), .issue_legal(issue_legal),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .ex_valid(ex_valid), .wb_we(wb_we), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [SELW-1:0]   s1;
        logic [SELW-1:0]   s2;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails = 0;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drv(input int v, input int rs1, input int u1, input int rs2, input int u2,
                       input int rd, input int rw, input int late);
        dec_valid    = 1'(v);
        dec_rs1      = REG_AW'(rs1);
        dec_use_rs1  = 1'(u1);
        dec_rs2      = REG_AW'(rs2);
        dec_use_rs2  = 1'(u2);
        dec_rd       = REG_AW'(rd);
        dec_regwrite = 1'(rw);
        dec_late     = 1'(late);
    endtask

    // One cycle: check decode-side outputs, queue the expected stage-0 record, then check EX and writeback.
    task automatic step(input string tag, input int es, input int ef, input int s1, input int s2);
        exp_t e;
        @(negedge clk);
        chk1({tag, "/stall"}, stall, 1'(es));
        chk1({tag, "/flush"}, flush, 1'(ef));
        e.v  = dec_valid & (es == 0) & (ef == 0);
        chk1({tag, "/issue"}, issue_legal, e.v);
        e.we = e.v & dec_regwrite & (dec_rd != '0);
        e.rd = dec_rd;
        e.s1 = e.v ? SELW'(s1) : '0;
        e.s2 = e.v ? SELW'(s2) : '0;
        q.push_back(e);
        @(posedge clk);
        #1;
        chk1({tag, "/ex_valid"}, ex_valid, q[$].v);
        chkw({tag, "/fwd_sel1"}, 8'(fwd_sel1), 8'(q[$].s1));
        chkw({tag, "/fwd_sel2"}, 8'(fwd_sel2), 8'(q[$].s2));
        chk1({tag, "/wb_we"}, wb_we, q[0].we);
        if (q[0].we) chkw({tag, "/wb_rd"}, 8'(wb_rd), 8'(q[0].rd));
        void'(q.pop_front());
    endtask

    task automatic issue(input string tag, input int n, input int s1, input int s2);
        for (int i = 0; i <= n; i++) step(tag, (i < n) ? 1 : 0, 0, s1, s2);
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step("idle", 0, 0, 0, 0);
    endtask

    // Expects dec_valid high on entry: the first post-reset cycle must issue.
    task automatic do_reset(input string tag);
        exp_t b;
        b.v = 1'b0; b.we = 1'b0; b.rd = '0; b.s1 = '0; b.s2 = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk1({tag, "/ex_valid"}, ex_valid, 1'b0);
        chk1({tag, "/wb_we"}, wb_we, 1'b0);
        chk1({tag, "/flush"}, flush, 1'b0);
        chk1({tag, "/stall"}, stall, 1'b0);
        chk1({tag, "/issue"}, issue_legal, 1'b1);
        chkw({tag, "/fwd_sel1"}, 8'(fwd_sel1), 8'd0);
        chkw({tag, "/fwd_sel2"}, 8'(fwd_sel2), 8'd0);
        q.delete();
        repeat (DEPTH - 1) q.push_back(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ex_branch_taken = 1'b1;
        drv(1, 5, 1, 6, 1, 7, 1, 1);
        do_reset("rst0");
        ex_branch_taken = 1'b0;
        step("post_rst0", 0, 0, 0, 0);
        idle(3);
        // ALU producer then immediate consumer
        drv(1, 0, 0, 0, 0, 5, 1, 0); issue("add_x5", 0, 0, 0);
        drv(1, 5, 1, 0, 0, 7, 1, 0); issue("raw_x5", FWD ? 0 : 3, FWD ? 1 : 0, 0);
        idle(3);
        // late producer then immediate consumer on rs2
        drv(1, 0, 0, 0, 0, 6, 1, 1); issue("load_x6", 0, 0, 0);
        drv(1, 0, 0, 6, 1, 8, 1, 0); issue("load_use", FWD ? 1 : 3, 0, FWD ? 2 : 0);
        idle(3);
        // x0 never creates a dependency nor a register write
        drv(1, 0, 0, 0, 0, 0, 1, 0); issue("x0_prod", 0, 0, 0);
        drv(1, 0, 1, 0, 0, 9, 1, 0); issue("x0_use", 0, 0, 0);
        idle(3);
        // youngest producer wins, each operand independently
        drv(1, 0, 0, 0, 0, 10, 1, 0); issue("p10a", 0, 0, 0);
        drv(1, 0, 0, 0, 0, 11, 1, 0); issue("p11", 0, 0, 0);
        drv(1, 0, 0, 0, 0, 10, 1, 0); issue("p10b", 0, 0, 0);
        drv(1, 10, 1, 11, 1, 12, 1, 0); issue("young", FWD ? 0 : 3, FWD ? 1 : 0, FWD ? 2 : 0);
        drv(1, 12, 0, 12, 0, 13, 1, 0); issue("no_use", 0, 0, 0);
        drv(1, 0, 0, 0, 0, 14, 0, 0); issue("no_wr", 0, 0, 0);
        drv(1, 14, 1, 14, 1, 15, 1, 0); issue("no_wr_use", 0, 0, 0);
        idle(3);
        // taken branch over a load-use hazard: flush wins for two slots
        drv(1, 0, 0, 0, 0, 6, 1, 1); issue("load_x6b", 0, 0, 0);
        drv(1, 0, 0, 6, 1, 16, 1, 0);
        ex_branch_taken = 1'b1; step("br_hz0", 0, 1, 0, 0);
        ex_branch_taken = 1'b0; step("br_hz1", 0, 1, 0, 0);
        issue("br_after", FWD ? 0 : 1, 0, 0);
        idle(3);
        // branch ignored while stage 0 holds a bubble
        drv(1, 0, 0, 0, 0, 17, 1, 0);
        ex_branch_taken = 1'b1; step("br_ign", 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 18, 1, 0);
        step("br_take", 0, 1, 0, 0);
        step("br_win", 0, 1, 0, 0);
        step("br_end", 0, 0, 0, 0);
        ex_branch_taken = 1'b0;
        idle(3);
        // reset with a full pipe
        drv(1, 0, 0, 0, 0, 19, 1, 0); issue("fill19", 0, 0, 0);
        drv(1, 0, 0, 0, 0, 20, 1, 0); issue("fill20", 0, 0, 0);
        drv(1, 20, 1, 0, 0, 21, 1, 0); issue("fill21", FWD ? 0 : 3, FWD ? 1 : 0, 0);
        drv(1, 21, 1, 0, 0, 22, 1, 1);
        do_reset("rst_full");
        issue("post_rst", 0, 0, 0);
        // reset inside a flush window
        drv(1, 0, 0, 0, 0, 23, 1, 0);
        ex_branch_taken = 1'b1; step("rf_br", 0, 1, 0, 0);
        ex_branch_taken = 1'b0;
        drv(1, 0, 0, 0, 0, 24, 1, 0);
        do_reset("rst_flush");
        step("post_rst2", 0, 0, 0, 0);
        idle(3);
        // reset during a stall
        drv(1, 0, 0, 0, 0, 25, 1, 1); issue("load_x25", 0, 0, 0);
        drv(1, 25, 1, 0, 0, 26, 1, 0); step("st_pre", 1, 0, 0, 0);
        do_reset("rst_stall");
        step("post_rst3", 0, 0, 0, 0);
        idle(3);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter DEPTH, 3, number of tracked post-decode stages; legal range 2..8; stage 0 = EX, stage DEPTH-1 = writeback.
REQ-002 Parameter REG_AW, 5, register index width.
REQ-003 Parameter FLUSH_CYCLES, 2, decode slots killed per taken branch, including the branch cycle; legal range 1..4.
REQ-004 One clock; reset is synchronous and active-low: ports clk and rst_n; all state changes on posedge clk only.
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 dec_valid  in  1  decode slot holds an instruction.
REQ-008 dec_rs1, dec_rs2  in  REG_AW  source indices; dec_use_rs1, dec_use_rs2  in  1  source used.
REQ-009 dec_rd  in  REG_AW  destination; dec_regwrite  in  1  writes rd; dec_late  in  1  result ready only at writeback (load, FPU-to-int).
REQ-010 ex_branch_taken  in  1  EX-stage branch/jump resolved taken.
REQ-011 stall  out  1  hold fetch/decode this cycle.
REQ-012 flush  out  1  decode slot killed this cycle.
REQ-013 issue_legal  out  1  decode instruction enters stage 0 this cycle.
REQ-014 fwd_sel1, fwd_sel2  out  SELW = max(1, clog2(DEPTH))  EX operand source: 0 = register file, k = stage-k result.
REQ-015 ex_valid  out  1  stage 0 holds a legal instruction.
REQ-016 wb_we  out  1  and wb_rd  out  REG_AW  register-file write port control.

Function
REQ-017 Per-stage record {valid, rd, regwrite, late}; every cycle st[k] <= st[k-1] for k>=1, and st[0] <= decode record with valid = issue_legal.
REQ-018 Stall does not freeze the pipe; st[1..] keep advancing, and st[0] receives a bubble.
REQ-019 Match(k, rs): st[k].valid & st[k].regwrite & rs != 0 & st[k].rd == rs & use flag set.
REQ-020 For a decode-time match at st[k], the producer sits at stage k+1 when the consumer is in EX; a non-late producer is forwardable from stages 1..DEPTH-1; a late producer is forwardable only from stage DEPTH-1; k+1 >= DEPTH selects 0.
REQ-021 stall = dec_valid & ~flush & (any matching late producer with k+1 < DEPTH-1).
REQ-022 fwd_sel = k+1 of the youngest (smallest k) match, or 0 if none; registered when issue_legal, cleared to 0 otherwise; no stale selects on bubbles.
REQ-023 A taken branch is honoured only when st[0].valid; it asserts flush that cycle and loads a counter so flush stays high for FLUSH_CYCLES-1 further cycles.
REQ-024 A taken branch during an active flush window restarts the counter.
REQ-025 Simultaneous flush and stall: flush wins and stall = 0.
REQ-026 issue_legal = dec_valid & ~stall & ~flush (combinational).
REQ-027 ex_valid = st[0].valid; wb_we = st[DEPTH-1].valid & regwrite & rd != 0; wb_rd = st[DEPTH-1].rd.

Reset
REQ-028 With rst_n low at a clk edge: all st valid = 0, flush counter = 0, fwd_sel = 0; outputs are then stall 0, flush 0, ex_valid 0, wb_we 0.
REQ-029 Reset mid-flush or mid-stall abandons the flush or stall; the first cycle after reset issues normally.

Configuration
REQ-030 Macro PIPE_HAZARD_CTRL_FWD_EN defined: forwarding per REQ-020..022.
REQ-031 Macro undefined: fwd_sel tied 0; stall whenever any match exists in st[0..DEPTH-1], regardless of late; flush behaviour unchanged.

Verification (DEPTH=3, FLUSH_CYCLES=2, FWD_EN defined unless noted)
REQ-032 Pipe full, rst_n low 1 cycle -> next cycle ex_valid=0, wb_we=0, flush=0, fwd_sel1=fwd_sel2=0.
REQ-033 Issue add x5, then next cycle rs1=x5 -> no stall; fwd_sel1=1 while consumer in EX.
REQ-034 Issue late load x6, then next cycle rs2=x6 -> stall exactly 1 cycle, then issue; fwd_sel2=2.
REQ-035 Producer rd=x0, consumer rs1=x0 -> no stall, fwd_sel1=0, wb_we=0 at writeback.
REQ-036 st[0] valid with ex_branch_taken=1 and a concurrent load-use hazard -> flush=1 for 2 cycles, stall=0, two decode slots not issued.
REQ-037 FWD_EN undefined, add x5 then consumer rs1=x5 -> stall 3 cycles, then issue with fwd_sel1=0.
